digit_serial_addsub: RTL and testbench

Parametrised successor to the single-bit Mealy serial adder. Adds or subtracts two WORD_W-bit two's-complement operands streamed LSB-first, DIGIT_W bits per beat. Sum digits leave combinationally in the same beat (Mealy). Word-level carry and overflow flags are registered. Sits in the serial datapath between shift-register operand sources and the serial result sink.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/digit_adder.sv | 33 +++
 rtl/digit_serial_addsub.sv | 153 +++++++++++++++
 tb/tb_digit_serial_addsub.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the digit-serial add/subtract datapath.
//   state_e  : word framing state (IDLE = no word open, RUN = word open)
//   MODE_*   : operation mode encoding latched on the first digit of a word
//   beats()  : number of digit beats per word
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned digit_w);
        return word_w / digit_w;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT_W-bit adder slice for the digit-serial datapath.
// Ports:
//   a, b      in  DIGIT_W  operand digits (b already conditioned for subtract)
//   cin       in  1        carry in
//   sum       out DIGIT_W  low DIGIT_W bits of a + b + cin
//   cout      out 1        carry out of the digit MSB
//   c_msb_in  out 1        carry into the digit MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module digit_adder #(
    parameter int unsigned DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);

    logic [DIGIT_W:0] w_full;

    always_comb begin
        w_full   = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        sum      = w_full[DIGIT_W-1:0];
        cout     = w_full[DIGIT_W];
        // Carry into the MSB column recovered from the MSB sum bit; avoids a
        // separate (DIGIT_W-1)-bit adder that would be empty when DIGIT_W == 1.
        c_msb_in = a[DIGIT_W-1] ^ b[DIGIT_W-1] ^ w_full[DIGIT_W-1];
    end

endmodule

// File: rtl/digit_serial_addsub.sv
// -----------------------------------------------------------------------------
// digit_serial_addsub
// Digit-serial two's-complement adder/subtractor. Operands arrive LSB digit
// first, DIGIT_W bits per beat; the sum digit is produced combinationally in
// the same beat. Word-level carry and signed overflow are registered when the
// MSB digit is accepted.
//
// Optional build macro: SERADD_PROTO_ERR_EN adds the proto_err output.
//
// Ports:
//   clock      in   1        system clock, rising edge
//   reset      in   1        asynchronous active-low reset
//   in_valid   in   1        beat qualifier
//   first      in   1        marks the LSB digit of a word
//   sub        in   1        0 = x+y, 1 = x-y (taken on the first beat)
//   x, y       in   DIGIT_W  operand digits
//   s          out  DIGIT_W  result digit (combinational, 0 when not accepted)
//   s_valid    out  1        s qualifier (combinational)
//   last       out  1        high on the MSB digit beat (combinational)
//   word_done  out  1        registered one-cycle pulse after the last beat
//   carry_out  out  1        registered word carry (1 = no borrow when sub)
//   overflow   out  1        registered signed overflow of the word
//   proto_err  out  1        (SERADD_PROTO_ERR_EN only) registered pulse after
//                            a stray beat in IDLE or a word abandoned by first
// -----------------------------------------------------------------------------
module digit_serial_addsub
    import serial_adder_pkg::*;
#(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned DIGIT_W = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               first,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [DIGIT_W-1:0] s,
    output logic               s_valid,
    output logic               last,
    output logic               word_done,
    output logic               carry_out,
    output logic               overflow
`ifdef SERADD_PROTO_ERR_EN
    ,
    output logic               proto_err
`endif
);

    localparam int unsigned BEATS = beats(WORD_W, DIGIT_W);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if (DIGIT_W == 0 || WORD_W == 0 || (WORD_W % DIGIT_W) != 0) begin : g_param_check
        $error("digit_serial_addsub: DIGIT_W must be non-zero and divide WORD_W");
    end

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_mode;
    logic               r_word_done;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_m;
    logic               w_cin;
    logic [DIGIT_W-1:0] w_yy;
    logic [DIGIT_W-1:0] w_sum;
    logic               w_cout;
    logic               w_c_msb_in;
    logic               w_accept;
    logic               w_last;

    // On a first beat the mode and carry come straight from sub, so a new word
    // (including back-to-back or abandoning ones) never sees stale state.
    always_comb begin
        w_m      = first ? sub : r_mode;
        w_cin    = first ? sub : r_carry;
        w_yy     = y ^ {DIGIT_W{w_m}};
        w_accept = in_valid & (first | (r_state == RUN));
        // A first beat always starts a fresh word, so it is only the last beat
        // when the word is a single digit.
        w_last   = w_accept & (first ? (BEATS == 1) : (r_cnt == LAST_CNT));
    end

    digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_adder (
        .a        (x),
        .b        (w_yy),
        .cin      (w_cin),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    always_comb begin
        s       = w_accept ? w_sum : '0;
        s_valid = w_accept;
        last    = w_last;
    end

`ifdef SERADD_PROTO_ERR_EN
    logic r_proto_err;
    assign proto_err = r_proto_err;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_mode      <= MODE_ADD;
            r_word_done <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef SERADD_PROTO_ERR_EN
            r_proto_err <= 1'b0;
`endif
        end else begin
            r_word_done <= 1'b0;
`ifdef SERADD_PROTO_ERR_EN
            r_proto_err <= in_valid &
                           ((~first & (r_state == IDLE)) | (first & (r_state == RUN)));
`endif
            if (w_accept) begin
                r_carry <= w_cout;
                if (first) begin
                    r_mode <= sub;
                    r_cnt  <= CNT_W'(1);
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                if (w_last) begin
                    r_carry_out <= w_cout;
                    r_overflow  <= w_c_msb_in ^ w_cout;
                    r_word_done <= 1'b1;
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                end else begin
                    r_state     <= RUN;
                end
            end
        end
    end

    assign word_done = r_word_done;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Four instances (DIGIT_W = 1, 2, 4, 8; WORD_W = 8) share clock and reset.
// Only one instance is driven at a time, so a single ordered scoreboard serves all.
module tb_digit_serial_addsub;

    logic       clock;
    logic       reset;
    logic       in_valid [4];
    logic       first    [4];
    logic       sub      [4];
    logic [7:0] xd       [4];
    logic [7:0] yd       [4];
    logic [7:0] sd       [4];
    logic       s_valid  [4];
    logic       last     [4];
    logic       word_done[4];
    logic       carry_out[4];
    logic       overflow [4];
    logic       proto_err[4];

    logic [0:0] s0;
    logic [1:0] s1;
    logic [3:0] s2;
    logic [7:0] s3;
    assign sd[0] = {7'b0, s0};
    assign sd[1] = {6'b0, s1};
    assign sd[2] = {4'b0, s2};
    assign sd[3] = s3;

`ifndef SERADD_PROTO_ERR_EN
    initial for (int i = 0; i < 4; i++) proto_err[i] = 1'b0;
`endif

    digit_serial_addsub #(.WORD_W(8), .DIGIT_W(1)) u_d1 (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .first(first[0]),
        .sub(sub[0]), .x(xd[0][0:0]), .y(yd[0][0:0]), .s(s0), .s_valid(s_valid[0]),
        .last(last[0]), .word_done(word_done[0]), .carry_out(carry_out[0]),
        .overflow(overflow[0])
`ifdef SERADD_PROTO_ERR_EN
        , .proto_err(proto_err[0])
`endif
    );
    digit_serial_addsub #(.WORD_W(8), .DIGIT_W(2)) u_d2 (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .first(first[1]),
        .sub(sub[1]), .x(xd[1][1:0]), .y(yd[1][1:0]), .s(s1), .s_valid(s_valid[1]),
        .last(last[1]), .word_done(word_done[1]), .carry_out(carry_out[1]),
        .overflow(overflow[1])
`ifdef SERADD_PROTO_ERR_EN
        , .proto_err(proto_err[1])
`endif
    );
    digit_serial_addsub #(.WORD_W(8), .DIGIT_W(4)) u_d4 (
        .clock(clock), .reset(reset), .in_valid(in_valid[2]), .first(first[2]),
        .sub(sub[2]), .x(xd[2][3:0]), .y(yd[2][3:0]), .s(s2), .s_valid(s_valid[2]),
        .last(last[2]), .word_done(word_done[2]), .carry_out(carry_out[2]),
        .overflow(overflow[2])
`ifdef SERADD_PROTO_ERR_EN
        , .proto_err(proto_err[2])
`endif
    );
    digit_serial_addsub #(.WORD_W(8), .DIGIT_W(8)) u_d8 (
        .clock(clock), .reset(reset), .in_valid(in_valid[3]), .first(first[3]),
        .sub(sub[3]), .x(xd[3]), .y(yd[3]), .s(s3), .s_valid(s_valid[3]),
        .last(last[3]), .word_done(word_done[3]), .carry_out(carry_out[3]),
        .overflow(overflow[3])
`ifdef SERADD_PROTO_ERR_EN
        , .proto_err(proto_err[3])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int k; logic [7:0] s; logic last; } beat_t;
    typedef struct { int k; logic c; logic v; } word_t;

    beat_t bq[$];
    word_t wq[$];
    int    pq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_proto(input int k);
`ifdef SERADD_PROTO_ERR_EN
        pq.push_back(k);
`else
        if (k < 0) pq.push_back(k);
`endif
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        beat_t b;
        word_t w;
        int    pk;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 4; k++) begin
                if (s_valid[k]) begin
                    if (bq.size() == 0) begin
                        chk("unexpected_s_valid", {31'b0, s_valid[k]}, 32'd0);
                    end else begin
                        b = bq.pop_front();
                        chk("beat_inst", k, b.k);
                        chk("s_digit", {24'b0, sd[k]}, {24'b0, b.s});
                        chk("last", {31'b0, last[k]}, {31'b0, b.last});
                    end
                end else begin
                    chk("idle_s_zero", {24'b0, sd[k]}, 32'd0);
                    chk("idle_last_zero", {31'b0, last[k]}, 32'd0);
                end
                if (word_done[k]) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_word_done", {31'b0, word_done[k]}, 32'd0);
                    end else begin
                        w = wq.pop_front();
                        chk("word_inst", k, w.k);
                        chk("carry_out", {31'b0, carry_out[k]}, {31'b0, w.c});
                        chk("overflow", {31'b0, overflow[k]}, {31'b0, w.v});
                    end
                end
                if (proto_err[k]) begin
                    if (pq.size() == 0) begin
                        chk("unexpected_proto_err", {31'b0, proto_err[k]}, 32'd0);
                    end else begin
                        pk = pq.pop_front();
                        chk("proto_inst", k, pk);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] dmask(input int k);
        logic [8:0] t;
        t = (9'd1 << (1 << k)) - 9'd1;
        return t[7:0];
    endfunction

    task automatic beat(input int k, input logic f, input logic sb,
                        input logic [7:0] xdig, input logic [7:0] ydig);
        in_valid[k] = 1'b1;
        first[k]    = f;
        sub[k]      = sb;
        xd[k]       = xdig;
        yd[k]       = ydig;
    endtask

    task automatic idle(input int k);
        in_valid[k] = 1'b0;
        first[k]    = 1'b0;
        sub[k]      = 1'b0;
        xd[k]       = 8'hFF;
        yd[k]       = 8'hFF;
    endtask

    // Streams one word; es/ec/ev are the hand-computed result, carry and overflow.
    task automatic send_word(input int k, input logic [7:0] xw, input logic [7:0] yw,
                             input logic sb, input logic [7:0] es, input logic ec,
                             input logic ev, input int stall_after, input int stall_len);
        int         dw;
        int         nb;
        logic [7:0] m;
        beat_t      b;
        word_t      w;
        dw = 1 << k;
        nb = 8 >> k;
        m  = dmask(k);
        for (int i = 0; i < nb; i++) begin
            beat(k, i == 0, (i == 0) ? sb : ~sb, (xw >> (i * dw)) & m, (yw >> (i * dw)) & m);
            b.k = k; b.s = (es >> (i * dw)) & m; b.last = (i == nb - 1);
            bq.push_back(b);
            if (i == nb - 1) begin
                w.k = k; w.c = ec; w.v = ev;
                wq.push_back(w);
            end
            @(posedge clock); #1;
            if (i == stall_after) begin
                idle(k);
                repeat (stall_len) begin @(posedge clock); #1; end
            end
        end
        idle(k);
    endtask

    task automatic check_all_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_s_valid"},   {31'b0, s_valid[k]},   32'd0);
            chk({tag, "_s"},         {24'b0, sd[k]},        32'd0);
            chk({tag, "_word_done"}, {31'b0, word_done[k]}, 32'd0);
            chk({tag, "_carry_out"}, {31'b0, carry_out[k]}, 32'd0);
            chk({tag, "_overflow"},  {31'b0, overflow[k]},  32'd0);
        end
    endtask

    initial begin
        beat_t b;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) idle(k);
        repeat (2) @(posedge clock);
        #1;
        check_all_reset("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // 1: D1 add 0x35 + 0x4A
        send_word(0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, -1, 0);
        repeat (2) @(posedge clock); #1;

        // 2: D2 add 0x7F + 0x01, then back-to-back sub 0x80 - 0x01
        send_word(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, 0);
        send_word(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1, 0);
        repeat (2) @(posedge clock); #1;

        // 3: D1 sub 0x10 - 0x20 with a 3-cycle stall after beat 3
        send_word(0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 3, 3);
        repeat (2) @(posedge clock); #1;

        // 4: D4, word abandoned after beat 0 by a new first (0xB + 0xD -> digit 8)
        beat(2, 1'b1, 1'b0, 8'h0B, 8'h0D);
        b.k = 2; b.s = 8'h08; b.last = 1'b0;
        bq.push_back(b);
        @(posedge clock); #1;
        push_proto(2);
        send_word(2, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, -1, 0);
        repeat (2) @(posedge clock); #1;

        // 6: D8 single-beat word, then a non-first beat must be ignored
        send_word(3, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, -1, 0);
        beat(3, 1'b0, 1'b0, 8'h11, 8'h22);
        push_proto(3);
        @(posedge clock); #1;
        idle(3);
        repeat (2) @(posedge clock); #1;

        // 5: D1 reset asserted during beat 4 (0x0F + 0x01 -> low bits 0)
        for (int i = 0; i < 4; i++) begin
            beat(0, i == 0, 1'b0, (8'h0F >> i) & 8'h01, (8'h01 >> i) & 8'h01);
            b.k = 0; b.s = 8'h00; b.last = 1'b0;
            bq.push_back(b);
            @(posedge clock); #1;
        end
        beat(0, 1'b0, 1'b0, 8'h01, 8'h01);
        #2 reset = 1'b0;
        #1 check_all_reset("midreset");
        @(posedge clock); #1;
        reset = 1'b1;
        push_proto(0);
        @(posedge clock); #1;
        idle(0);
        @(posedge clock); #1;
        send_word(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
        repeat (4) @(posedge clock); #1;

        chk("beat_queue_drained", bq.size(), 32'd0);
        chk("word_queue_drained", wq.size(), 32'd0);
        chk("proto_queue_drained", pq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
